// File: rtl/clock_enable_gen_v.sv
`default_nettype none
// ============================================================================
//  Module      : clock_enable_gen_v
//  Description : NUM_CH independent clock-enable channels from one clock.
//                Each channel has its own divisor and mode (HALT/RUN/STEP).
//                It produces a one-cycle tick, a 50%-duty divided level and
//                a running flag. None of these outputs is used as a clock.
//  Revision    : 1.0  initial release
// ============================================================================
module clock_enable_gen_v #(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 16,
    parameter int          CH_W        = 2,
    parameter int          DEFAULT_DIV = 50,
    parameter logic [1:0]  RESET_MODE  = 2'b01
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [1:0]        cfg_mode,
    input  logic [NUM_CH-1:0] step,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_lvl,
    output logic [NUM_CH-1:0] running
);

    localparam logic [1:0]       c_mode_run  = 2'b01;
    localparam logic [1:0]       c_mode_step = 2'b10;
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_rst_div   = CNT_W'(DEFAULT_DIV);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [1:0]       mode_q, mode_d;
        logic             tick_q, tick_d;
        logic             lvl_q, lvl_d;
        logic             step_q, step_d;
        logic             running_q, running_d;
        logic [CNT_W-1:0] w_div_eff;
        logic             w_wr;

        // A divisor of zero behaves as one; the write strobe is decoded per channel.
        // An out-of-range cfg_ch never matches any channel index.
        assign w_div_eff = (div_q == '0) ? c_one : div_q;
        assign w_wr      = cfg_we && (cfg_ch == CH_W'(i));

        // Next-state: a config write overrides the mode behaviour, including a step edge.
        always_comb begin
            cnt_d     = cnt_q;
            div_d     = div_q;
            mode_d    = mode_q;
            tick_d    = 1'b0;
            lvl_d     = lvl_q;
            step_d    = step[i];
            if (w_wr) begin
                div_d  = cfg_div;
                mode_d = cfg_mode;
                cnt_d  = '0;
            end else begin
                case (mode_q)
                    c_mode_run: begin
                        if (cnt_q == w_div_eff - c_one) begin
                            cnt_d  = '0;
                            tick_d = 1'b1;
                            lvl_d  = ~lvl_q;
                        end else begin
                            cnt_d  = cnt_q + c_one;
                        end
                    end
                    c_mode_step: begin
                        cnt_d = '0;
                        if (step[i] && !step_q) begin
                            tick_d = 1'b1;
                            lvl_d  = ~lvl_q;
                        end
                    end
                    default: begin
                        // HALT (00 and 11): counter and level frozen, no tick.
                        cnt_d = cnt_q;
                    end
                endcase
            end
            running_d = (mode_d == c_mode_run);
        end

        // Channel state registers with synchronous reset.
        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q     <= '0;
                div_q     <= c_rst_div;
                mode_q    <= RESET_MODE;
                tick_q    <= 1'b0;
                lvl_q     <= 1'b0;
                step_q    <= 1'b0;
                running_q <= (RESET_MODE == c_mode_run);
            end else begin
                cnt_q     <= cnt_d;
                div_q     <= div_d;
                mode_q    <= mode_d;
                tick_q    <= tick_d;
                lvl_q     <= lvl_d;
                step_q    <= step_d;
                running_q <= running_d;
            end
        end

        assign tick[i]    = tick_q;
        assign clk_lvl[i] = lvl_q;
        assign running[i] = running_q;
    end

endmodule
`default_nettype wire
